// File: rtl/map_table_request_sequencer_if.sv
// Bundle of request, grant and map-table strobe signals around the map table request sequencer.
// slave is the sequencer's view; master is the view of dispatch/ROB/branch unit and map table.
interface map_table_request_sequencer_if #(
  parameter int CHECKPOINT_COLUMNS = 4,
  parameter int ARCH_W             = 5,
  parameter int PHYS_W             = 7,
  parameter int ROB_W              = 6
);
  localparam int COL_W = $clog2(CHECKPOINT_COLUMNS);

  logic              rob_revert_req;
  logic [ARCH_W-1:0] rob_revert_arch_tag;
  logic [PHYS_W-1:0] rob_revert_safe_phys_tag;
  logic [PHYS_W-1:0] rob_revert_spec_phys_tag;
  logic              rob_revert_ready;

  logic              br_restore_req;
  logic              br_restore_speculate_failed;
  logic [ROB_W-1:0]  br_restore_ROB_index;
  logic [COL_W-1:0]  br_restore_safe_column;
  logic              br_restore_ready;

  logic              dispatch_save_req;
  logic [ROB_W-1:0]  dispatch_save_ROB_index;
  logic              dispatch_save_ready;
  logic [COL_W-1:0]  dispatch_save_safe_column;

  logic              dispatch_rename_req;
  logic [ARCH_W-1:0] dispatch_rename_arch_tag;
  logic [PHYS_W-1:0] dispatch_rename_phys_tag;
  logic              dispatch_rename_ready;

  logic              mt_revert_valid;
  logic [ARCH_W-1:0] mt_revert_arch_tag;
  logic [PHYS_W-1:0] mt_revert_safe_phys_tag;
  logic [PHYS_W-1:0] mt_revert_spec_phys_tag;
  logic              mt_restore_checkpoint_valid;
  logic              mt_restore_checkpoint_speculate_failed;
  logic [ROB_W-1:0]  mt_restore_checkpoint_ROB_index;
  logic [COL_W-1:0]  mt_restore_checkpoint_safe_column;
  logic              mt_restore_checkpoint_success;
  logic              mt_save_checkpoint_valid;
  logic [ROB_W-1:0]  mt_save_checkpoint_ROB_index;
  logic [COL_W-1:0]  mt_save_checkpoint_safe_column;
  logic              mt_rename_valid;
  logic [ARCH_W-1:0] mt_rename_arch_tag;
  logic [PHYS_W-1:0] mt_rename_phys_tag;

  logic [COL_W-1:0]  live_checkpoints;
  logic              restore_drop;
  logic              dispatch_stall;

  modport slave (
    input  rob_revert_req, rob_revert_arch_tag, rob_revert_safe_phys_tag, rob_revert_spec_phys_tag,
    input  br_restore_req, br_restore_speculate_failed, br_restore_ROB_index, br_restore_safe_column,
    input  dispatch_save_req, dispatch_save_ROB_index,
    input  dispatch_rename_req, dispatch_rename_arch_tag, dispatch_rename_phys_tag,
    input  mt_restore_checkpoint_success, mt_save_checkpoint_safe_column,
    output rob_revert_ready, br_restore_ready, dispatch_save_ready, dispatch_save_safe_column,
    output dispatch_rename_ready,
    output mt_revert_valid, mt_revert_arch_tag, mt_revert_safe_phys_tag, mt_revert_spec_phys_tag,
    output mt_restore_checkpoint_valid, mt_restore_checkpoint_speculate_failed,
    output mt_restore_checkpoint_ROB_index, mt_restore_checkpoint_safe_column,
    output mt_save_checkpoint_valid, mt_save_checkpoint_ROB_index,
    output mt_rename_valid, mt_rename_arch_tag, mt_rename_phys_tag,
    output live_checkpoints, restore_drop, dispatch_stall
  );

  modport master (
    output rob_revert_req, rob_revert_arch_tag, rob_revert_safe_phys_tag, rob_revert_spec_phys_tag,
    output br_restore_req, br_restore_speculate_failed, br_restore_ROB_index, br_restore_safe_column,
    output dispatch_save_req, dispatch_save_ROB_index,
    output dispatch_rename_req, dispatch_rename_arch_tag, dispatch_rename_phys_tag,
    output mt_restore_checkpoint_success, mt_save_checkpoint_safe_column,
    input  rob_revert_ready, br_restore_ready, dispatch_save_ready, dispatch_save_safe_column,
    input  dispatch_rename_ready,
    input  mt_revert_valid, mt_revert_arch_tag, mt_revert_safe_phys_tag, mt_revert_spec_phys_tag,
    input  mt_restore_checkpoint_valid, mt_restore_checkpoint_speculate_failed,
    input  mt_restore_checkpoint_ROB_index, mt_restore_checkpoint_safe_column,
    input  mt_save_checkpoint_valid, mt_save_checkpoint_ROB_index,
    input  mt_rename_valid, mt_rename_arch_tag, mt_rename_phys_tag,
    input  live_checkpoints, restore_drop, dispatch_stall
  );
endinterface

// File: rtl/map_table_request_sequencer.sv
// Fixed-priority single-issue sequencer for the register map table: revert > restore > save > rename,
// with a restore FIFO, bounded restore retries, live checkpoint tracking and a post-flush dispatch bubble.
module map_table_request_sequencer #(
  parameter int CHECKPOINT_COLUMNS  = 4,
  parameter int RESTORE_QUEUE_DEPTH = 4,
  parameter int MAX_RESTORE_RETRIES = 3,
  parameter int ROB_W               = 6
) (
  input logic CLK,
  input logic RST,
  map_table_request_sequencer_if.slave bus
);
  localparam int COL_W = $clog2(CHECKPOINT_COLUMNS);
  localparam int PTR_W = $clog2(RESTORE_QUEUE_DEPTH);
  localparam int CNT_W = $clog2(RESTORE_QUEUE_DEPTH + 1);
  localparam int RTY_W = $clog2(MAX_RESTORE_RETRIES + 1);
  localparam logic [COL_W-1:0] LIVE_MAX  = COL_W'(CHECKPOINT_COLUMNS - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(RESTORE_QUEUE_DEPTH);
  localparam logic [RTY_W-1:0] LAST_TRY  = RTY_W'(MAX_RESTORE_RETRIES - 1);

  typedef struct packed {
    logic             failed;
    logic [ROB_W-1:0] rob;
    logic [COL_W-1:0] col;
  } rq_entry_t;

  typedef enum logic [2:0] {GNT_NONE, GNT_REVERT, GNT_RESTORE, GNT_SAVE, GNT_RENAME} grant_e;

  rq_entry_t        fifo_q [RESTORE_QUEUE_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [COL_W-1:0] live_q, live_d;
  logic             stall_q, stall_d;

  grant_e    grant;
  rq_entry_t head_e;
  logic      not_full, enq, issued, succ, flush, drop, pop;

  always_comb begin
    head_e   = fifo_q[head_q];
    not_full = (count_q != FIFO_FULL);
    grant    = GNT_NONE;
    if (bus.rob_revert_req)
      grant = GNT_REVERT;
    else if (count_q != '0)
      grant = GNT_RESTORE;
    else if (bus.dispatch_save_req && (live_q < LIVE_MAX) && !stall_q)
      grant = GNT_SAVE;
    else if (bus.dispatch_rename_req && !stall_q)
      grant = GNT_RENAME;

    enq    = bus.br_restore_req && not_full;
    issued = (grant == GNT_RESTORE);
    succ   = bus.mt_restore_checkpoint_success;
    flush  = issued && succ && head_e.failed;
    drop   = issued && !succ && (retry_q == LAST_TRY);
    pop    = issued && ((succ && !head_e.failed) || drop);
  end

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(enq);
    count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
    retry_d = retry_q;
    live_d  = live_q;
    stall_d = (grant == GNT_REVERT) || flush;

    // A speculation flush also discards whatever is being enqueued this cycle.
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    if (flush || pop)
      retry_d = '0;
    else if (issued)
      retry_d = retry_q + RTY_W'(1);

    if ((grant == GNT_REVERT) || flush)
      live_d = '0;
    else if (grant == GNT_SAVE)
      live_d = live_q + COL_W'(1);
    else if (pop && !drop && (live_q != '0))
      live_d = live_q - COL_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      retry_q <= '0;
      live_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      retry_q <= retry_d;
      live_q  <= live_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq)
      fifo_q[tail_q] <= '{failed: bus.br_restore_speculate_failed,
                          rob:    bus.br_restore_ROB_index,
                          col:    bus.br_restore_safe_column};
  end

  always_comb begin
    bus.rob_revert_ready          = (grant == GNT_REVERT);
    bus.br_restore_ready          = not_full;
    bus.dispatch_save_ready       = (grant == GNT_SAVE);
    bus.dispatch_rename_ready     = (grant == GNT_RENAME);
    bus.dispatch_save_safe_column = bus.mt_save_checkpoint_safe_column;
    bus.live_checkpoints          = live_q;
    bus.dispatch_stall            = stall_q;
    bus.restore_drop              = drop;

    bus.mt_revert_valid                        = 1'b0;
    bus.mt_revert_arch_tag                     = '0;
    bus.mt_revert_safe_phys_tag                = '0;
    bus.mt_revert_spec_phys_tag                = '0;
    bus.mt_restore_checkpoint_valid            = 1'b0;
    bus.mt_restore_checkpoint_speculate_failed = 1'b0;
    bus.mt_restore_checkpoint_ROB_index        = '0;
    bus.mt_restore_checkpoint_safe_column      = '0;
    bus.mt_save_checkpoint_valid               = 1'b0;
    bus.mt_save_checkpoint_ROB_index           = '0;
    bus.mt_rename_valid                        = 1'b0;
    bus.mt_rename_arch_tag                     = '0;
    bus.mt_rename_phys_tag                     = '0;

    unique case (grant)
      GNT_REVERT: begin
        bus.mt_revert_valid         = 1'b1;
        bus.mt_revert_arch_tag      = bus.rob_revert_arch_tag;
        bus.mt_revert_safe_phys_tag = bus.rob_revert_safe_phys_tag;
        bus.mt_revert_spec_phys_tag = bus.rob_revert_spec_phys_tag;
      end
      GNT_RESTORE: begin
        bus.mt_restore_checkpoint_valid            = 1'b1;
        bus.mt_restore_checkpoint_speculate_failed = head_e.failed;
        bus.mt_restore_checkpoint_ROB_index        = head_e.rob;
        bus.mt_restore_checkpoint_safe_column      = head_e.col;
      end
      GNT_SAVE: begin
        bus.mt_save_checkpoint_valid     = 1'b1;
        bus.mt_save_checkpoint_ROB_index = bus.dispatch_save_ROB_index;
      end
      GNT_RENAME: begin
        bus.mt_rename_valid    = 1'b1;
        bus.mt_rename_arch_tag = bus.dispatch_rename_arch_tag;
        bus.mt_rename_phys_tag = bus.dispatch_rename_phys_tag;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/map_table_request_sequencer.md
# map_table_request_sequencer

Arbitrates and sequences all requests to the physical register map table: ROB reverts, branch-resolution checkpoint restores, dispatch checkpoint saves and dispatch renames. At most one operation is issued per cycle, under a fixed priority. Restore requests are buffered in a small FIFO, and failed restores are retried a bounded number of times. The block tracks live checkpoint columns and throttles dispatch after flush events. It sits in the core between dispatch, ROB and branch resolution on one side and the map table on the other.

## Interface
Parameters:
- CHECKPOINT_COLUMNS, 4: map table columns; at most CHECKPOINT_COLUMNS-1 live checkpoints.
- RESTORE_QUEUE_DEPTH, 4: restore FIFO entries (power of 2).
- MAX_RESTORE_RETRIES, 3: failed issues before a restore is dropped.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- rob_revert_req  in  1  ROB revert request.
- rob_revert_arch_tag / safe_phys_tag / spec_phys_tag  in  arch_reg_tag_t / phys_reg_tag_t / phys_reg_tag_t  revert payload.
- rob_revert_ready  out  1  revert issued this cycle.
- br_restore_req  in  1  enqueue restore.
- br_restore_speculate_failed  in  1  restore payload.
- br_restore_ROB_index  in  ROB_index_t  restore payload.
- br_restore_safe_column  in  checkpoint_column_t  restore payload.
- br_restore_ready  out  1  FIFO not full.
- dispatch_save_req  in  1  save request.
- dispatch_save_ROB_index  in  ROB_index_t  save payload.
- dispatch_save_ready  out  1  save issued.
- dispatch_save_safe_column  out  checkpoint_column_t  pass-through of mt_save_checkpoint_safe_column.
- dispatch_rename_req  in  1  rename request.
- dispatch_rename_arch_tag / phys_tag  in  arch_reg_tag_t / phys_reg_tag_t  rename payload.
- dispatch_rename_ready  out  1  rename issued.
- mt_revert_valid, mt_restore_checkpoint_valid, mt_save_checkpoint_valid, mt_rename_valid  out  1  map-table strobes; at most one high per cycle.
- mt_* payload outputs  out  matching types  driven from the granted source; 0 when not granted.
- mt_restore_checkpoint_success  in  1  same-cycle result from map table.
- mt_save_checkpoint_safe_column  in  checkpoint_column_t  map table working column.
- live_checkpoints  out  $clog2(CHECKPOINT_COLUMNS)  live checkpoint count.
- restore_drop  out  1  pulse: head restore discarded after retries.
- dispatch_stall  out  1  registered post-flush bubble.

## Operation
- Priority, combinational on the current-cycle inputs and registered state: revert > restore (FIFO non-empty) > save > rename.
  - Save is eligible only when live_checkpoints < CHECKPOINT_COLUMNS-1 and dispatch_stall=0.
  - Rename is eligible only when dispatch_stall=0.
- Restore FIFO: head/tail pointers plus count.
  - Enqueue when br_restore_req & br_restore_ready. br_restore_ready is based on the registered count, so a full FIFO refuses enqueue even when it pops in the same cycle.
  - The head issues as mt_restore_*.
- Restore outcome, when issued:
  - success & !speculate_failed: pop; live_checkpoints -= 1, saturating at 0.
  - success & speculate_failed: flush the entire FIFO, including any same-cycle enqueue; live_checkpoints := 0; dispatch_stall := 1 next cycle.
  - !success: retry_cnt += 1. If retry_cnt reaches MAX_RESTORE_RETRIES, pop the head, pulse restore_drop and clear retry_cnt.
  - Every pop or flush clears retry_cnt.
- Revert issue: live_checkpoints := 0; dispatch_stall := 1 next cycle; FIFO unchanged.
- Save issue: live_checkpoints += 1.
- dispatch_stall stays high for exactly one cycle, unless re-triggered.

## Timing
- Grant and ready outputs are combinational, with zero-cycle latency from request to mt_* strobe. Counter, FIFO and stall updates take effect at the next CLK edge.
- Reset values: FIFO empty, retry_cnt=0, live_checkpoints=0, dispatch_stall=0, restore_drop=0, all mt_* strobes 0, br_restore_ready=1. RST asserted mid-operation aborts all queued restores immediately (asynchronous).
- Pointers wrap modulo RESTORE_QUEUE_DEPTH.
- A request that loses arbitration must hold its payload until its ready is seen.

## Test plan
- Reset, then rename_req with arch 5 / phys 40 -> same cycle mt_rename_valid=1 with payload 5/40, dispatch_rename_ready=1; live_checkpoints=0.
- Save, revert and rename all requested together -> only mt_revert_valid; next cycle dispatch_stall=1 and save/rename blocked; cycle after that, save granted and live_checkpoints becomes 1.
- Three saves issued -> live_checkpoints=3. A fourth save_req -> dispatch_save_ready=0. A restore with success & !failed -> count 2, and the save is granted next cycle.
- Fill FIFO with 4 restores -> br_restore_ready=0. Fifth req while head pops -> not enqueued, and count becomes 3.
- Head restore with success held 0 -> retried 3 cycles, restore_drop pulses on the 3rd, next entry issues on the 4th.
- Failed-speculation restore succeeds while 2 entries are queued and a new one is enqueuing -> FIFO empty, live_checkpoints=0, dispatch_stall=1 next cycle.
